// File: rtl/block_state_store_if.sv
// Brick-hit request/acknowledge channel between the ball collision logic and the brick map.
interface block_state_store_if;
  logic       hit_valid;
  logic [3:0] hit_row;
  logic [3:0] hit_col;
  logic       hit_ready;
  logic       hit_ack;
  logic       hit_present;

  modport master (
    output hit_valid, hit_row, hit_col,
    input  hit_ready, hit_ack, hit_present
  );

  modport slave (
    input  hit_valid, hit_row, hit_col,
    output hit_ready, hit_ack, hit_present
  );
endinterface

// File: rtl/block_state_store.sv
// Breakout brick presence map: row readout for the painter, hit clears, level refill, brick count.
module block_state_store #(
  parameter int unsigned BLOCKS_PER_ROW = 13,
  parameter int unsigned NUM_ROWS       = 16,
  parameter int unsigned COUNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  input  logic                      refill_req,
  output logic                      busy,
  output logic [COUNT_W-1:0]        blocks_left,
  output logic                      all_cleared,
  block_state_store_if.slave        hit
);

  localparam int unsigned ROW_W = 4;
  localparam logic [COUNT_W-1:0] TotalBlocks = COUNT_W'(BLOCKS_PER_ROW * NUM_ROWS);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                    state_q;
  logic [BLOCKS_PER_ROW-1:0] map_q [NUM_ROWS];
  logic [ROW_W-1:0]          read_row_q;
  logic [ROW_W-1:0]          fill_row_q;
  logic [COUNT_W-1:0]        blocks_left_q;
  logic                      hit_ack_q;
  logic                      hit_present_q;

  logic col_ok;
  logic hit_bit;
  logic accept;

  always_comb begin
    col_ok  = hit.hit_col < 4'(BLOCKS_PER_ROW);
    // Out-of-range columns are masked so they never read past the row width.
    hit_bit = col_ok & map_q[hit.hit_row][hit.hit_col];
    accept  = hit.hit_valid & hit.hit_ready;
  end

  assign hit.hit_ready    = (state_q == StIdle) && !refill_req;
  assign hit.hit_ack      = hit_ack_q;
  assign hit.hit_present  = hit_present_q;
  assign block_line_state = map_q[read_row_q];
  assign busy             = (state_q == StFill);
  assign blocks_left      = blocks_left_q;
  assign all_cleared      = (blocks_left_q == '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= StIdle;
      read_row_q    <= '0;
      fill_row_q    <= '0;
      blocks_left_q <= TotalBlocks;
      hit_ack_q     <= 1'b0;
      hit_present_q <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        map_q[r] <= '1;
      end
    end else begin
      if (new_frame) begin
        read_row_q <= '0;
      end else if (go_next_line) begin
        read_row_q <= read_row_q + ROW_W'(1);
      end

      hit_ack_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (refill_req) begin
            state_q    <= StFill;
            fill_row_q <= '0;
          end else if (accept) begin
            hit_ack_q     <= 1'b1;
            hit_present_q <= hit_bit;
            if (hit_bit) begin
              map_q[hit.hit_row][hit.hit_col] <= 1'b0;
              blocks_left_q <= blocks_left_q - COUNT_W'(1);
            end
          end
        end
        StFill: begin
          map_q[fill_row_q] <= '1;
          fill_row_q        <= fill_row_q + ROW_W'(1);
          if (fill_row_q == ROW_W'(NUM_ROWS - 1)) begin
            state_q       <= StIdle;
            blocks_left_q <= TotalBlocks;
          end
        end
      endcase
    end
  end

endmodule
